// File: rtl/btn_pkg.sv
// Shared types and default 25 MHz timing constants for the push-button front-end.
package btn_pkg;

    localparam int CLK_HZ        = 25_000_000;
    localparam int DEBOUNCE_10MS = CLK_HZ / 100;
    localparam int REPEAT_0P5S   = CLK_HZ / 2;
    localparam int REPEAT_0P1S   = CLK_HZ / 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    // Counter width able to hold values 0..count-1, never narrower than one bit.
    function automatic int width_for(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, counter debouncer and hold-to-repeat FSM.
// Input is already polarity-corrected, so 1 always means pressed.
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int REPEAT_DELAY    = REPEAT_0P5S,
    parameter int REPEAT_RATE     = REPEAT_0P1S
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_pressed,
    input  logic repeat_en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W   = width_for(DEBOUNCE_CYCLES);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMR_W   = width_for(TMR_MAX);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_channel: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_channel: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("btn_channel: REPEAT_DELAY must be at least 1");
    end
    if (REPEAT_RATE < 1) begin : g_bad_rate
        $error("btn_channel: REPEAT_RATE must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   stable;
    logic [CNT_W-1:0]       cnt;
    logic                   accept;
    logic                   accept_rise;
    logic                   accept_fall;
    rpt_state_t             state;
    logic [TMR_W-1:0]       timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw_pressed};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // A level change is accepted on the cycle its run of differing samples completes.
    assign accept      = (s != stable) && (cnt == CNT_LAST);
    assign accept_rise = accept && s;
    assign accept_fall = accept && !s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (s == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= s;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = stable;

    // Release wins over any repeat pulse due in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            timer         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (accept_fall) begin
                release_pulse <= 1'b1;
                state         <= ST_IDLE;
                timer         <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept_rise) begin
                            press_pulse <= 1'b1;
                            state       <= ST_DELAY;
                            timer       <= '0;
                        end
                    end
                    ST_DELAY: begin
                        if (timer == DELAY_LAST) begin
                            if (repeat_en) begin
                                press_pulse <= 1'b1;
                                timer       <= '0;
                                state       <= ST_REPEAT;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!repeat_en) begin
                            state <= ST_DELAY;
                            timer <= DELAY_LAST;
                        end else if (timer == RATE_LAST) begin
                            press_pulse <= 1'b1;
                            timer       <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// N-channel button front-end: polarity correction, per-channel conditioning,
// enable gating of the pulse outputs and the any-press reduction.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int               N_BTN           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int               REPEAT_DELAY    = REPEAT_0P5S,
    parameter int               REPEAT_RATE     = REPEAT_0P1S,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = {N_BTN{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             btn_any_press
);

    if (N_BTN < 1) begin : g_bad_n
        $error("btn_conditioner: N_BTN must be at least 1");
    end

    logic [N_BTN-1:0] pressed_raw;
    logic [N_BTN-1:0] level_int;
    logic [N_BTN-1:0] press_int;
    logic [N_BTN-1:0] release_int;

    assign pressed_raw = btn_raw ^ ACTIVE_LOW_MASK;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_channel (
            .clk           (clk),
            .rst_n         (rst_n),
            .raw_pressed   (pressed_raw[i]),
            .repeat_en     (repeat_en[i]),
            .level         (level_int[i]),
            .press_pulse   (press_int[i]),
            .release_pulse (release_int[i])
        );
    end

    // Channels keep running while disabled; only the pulses are hidden and never replayed.
    assign btn_level     = level_int;
    assign btn_press     = press_int & {N_BTN{ena}};
    assign btn_release   = release_int & {N_BTN{ena}};
    assign btn_any_press = |btn_press;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: window-based debounce / gap-based repeat model
// compared every cycle, plus directed scenarios with hand-computed timings.
module tb_btn_conditioner;

    localparam int         N    = 4;
    localparam int         SYNC = 2;
    localparam int         DC   = 4;
    localparam int         RD   = 8;
    localparam int         RR   = 3;
    localparam int         WIN  = SYNC + DC - 1;
    localparam logic [3:0] MASK = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] btn_raw;
    logic [3:0] repeat_en;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       btn_any_press;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN           (N),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .ACTIVE_LOW_MASK (MASK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .btn_raw       (btn_raw),
        .repeat_en     (repeat_en),
        .btn_level     (btn_level),
        .btn_press     (btn_press),
        .btn_release   (btn_release),
        .btn_any_press (btn_any_press)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        int ch;
        bit is_press;
    } ev_t;
    ev_t ev_q[$];

    bit         hist [N][WIN];
    bit         lvl [N];
    int         since [N];
    int         need [N];
    bit         repeating [N];
    logic [3:0] m_level;
    logic [3:0] m_press;
    logic [3:0] m_rel;

    task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] raw, input logic [3:0] ren, input logic en, input int n);
        btn_raw   = raw;
        repeat_en = ren;
        ena       = en;
        tick(n);
    endtask

    function automatic int count_ev(input int ch, input bit is_press, input int from, input int to);
        int n = 0;
        foreach (ev_q[i])
            if (ev_q[i].ch == ch && ev_q[i].is_press == is_press && ev_q[i].cyc >= from && ev_q[i].cyc <= to)
                n++;
        return n;
    endfunction

    function automatic int nth_ev(input int ch, input bit is_press, input int nth);
        int k = 0;
        foreach (ev_q[i])
            if (ev_q[i].ch == ch && ev_q[i].is_press == is_press) begin
                if (k == nth) return ev_q[i].cyc;
                k++;
            end
        return -1000;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            for (int i = 0; i < WIN; i++) hist[c][i] = 1'b0;
            lvl[c]       = 1'b0;
            since[c]     = 0;
            need[c]      = RD;
            repeating[c] = 1'b0;
        end
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
    endtask

    // Level flips once the last DC synchronised samples all disagree with it;
    // repeats fire when enabled and the gap since the previous press is long enough.
    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            bit now_p;
            bit flip;
            now_p = btn_raw[c] ^ MASK[c];
            flip  = 1'b1;
            for (int j = 0; j < DC; j++)
                if (hist[c][SYNC-1+j] == lvl[c]) flip = 1'b0;
            for (int i = WIN - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = now_p;
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            if (flip) begin
                lvl[c] = !lvl[c];
                if (lvl[c]) begin
                    m_press[c]   = 1'b1;
                    since[c]     = 0;
                    need[c]      = RD;
                    repeating[c] = 1'b0;
                end else begin
                    m_rel[c] = 1'b1;
                end
            end else if (lvl[c]) begin
                if (repeating[c] && !repeat_en[c]) begin
                    repeating[c] = 1'b0;
                    need[c]      = 1;
                    since[c]++;
                end else if (repeat_en[c] && since[c] + 1 >= need[c]) begin
                    m_press[c]   = 1'b1;
                    since[c]     = 0;
                    need[c]      = RR;
                    repeating[c] = 1'b1;
                end else begin
                    since[c]++;
                end
            end
            m_level[c] = lvl[c];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        check_output("level", btn_level, m_level);
        check_output("press", btn_press, m_press & {4{ena}});
        check_output("release", btn_release, m_rel & {4{ena}});
        check_output("any_press", {3'b0, btn_any_press}, {3'b0, |(m_press & {4{ena}})});
        for (int c = 0; c < N; c++) begin
            ev_t e;
            e.cyc = cyc;
            e.ch  = c;
            if (btn_press[c]) begin
                e.is_press = 1'b1;
                ev_q.push_back(e);
            end
            if (btn_release[c]) begin
                e.is_press = 1'b0;
                ev_q.push_back(e);
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int r, a, d, u;
        rst_n = 1'b0;
        apply_stimulus(MASK, 4'b0000, 1'b1, 3);
        check_output("reset_level", btn_level, 4'b0000);
        check_output("reset_press", btn_press, 4'b0000);

        // Release reset with channel 0 held: accepted on the 6th edge.
        btn_raw = MASK | 4'b0001;
        rst_n   = 1'b1;
        tick(5);
        check_output("latency_level_early", btn_level, 4'b0000);
        tick(1);
        check_output("latency_level", btn_level, 4'b0001);
        check_output("latency_press", btn_press, 4'b0001);
        check_output("latency_any", {3'b0, btn_any_press}, 4'b0001);
        tick(1);
        check_output("press_width", btn_press, 4'b0000);

        // Asynchronous reset mid-clock, then a fresh press after full latency.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_reset_level", btn_level, 4'b0000);
        check_output("async_reset_press", btn_press, 4'b0000);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check_output("rereset_level_early", btn_level, 4'b0000);
        tick(1);
        check_output("rereset_press", btn_press, 4'b0001);
        apply_stimulus(MASK, 4'b0000, 1'b1, 10);

        // Bounce on channel 1.
        ev_q.delete();
        for (int i = 0; i < 8; i++)
            apply_stimulus((i % 2 == 0) ? (MASK | 4'b0010) : MASK, 4'b0000, 1'b1, 1);
        r = cyc + 1;
        apply_stimulus(MASK | 4'b0010, 4'b0000, 1'b1, 12);
        check_int("bounce_press_count", count_ev(1, 1'b1, 0, cyc), 1);
        check_int("bounce_press_edge", nth_ev(1, 1'b1, 0) - r + 1, 6);
        check_int("bounce_release_count", count_ev(1, 1'b0, 0, cyc), 0);
        apply_stimulus(MASK, 4'b0000, 1'b1, 10);

        // Auto-repeat on channel 2, held 30 cycles after acceptance.
        ev_q.delete();
        r = cyc + 1;
        apply_stimulus(MASK | 4'b0100, 4'b0100, 1'b1, 36);
        d = cyc + 1;
        apply_stimulus(MASK, 4'b0100, 1'b1, 10);
        a = nth_ev(2, 1'b1, 0);
        check_int("rpt_accept_edge", a - r + 1, 6);
        check_int("rpt_first", nth_ev(2, 1'b1, 1) - a, 8);
        check_int("rpt_second", nth_ev(2, 1'b1, 2) - a, 11);
        check_int("rpt_third", nth_ev(2, 1'b1, 3) - a, 14);
        check_int("rpt_release_edge", nth_ev(2, 1'b0, 0) - d + 1, 6);
        check_int("rpt_release_count", count_ev(2, 1'b0, 0, cyc), 1);

        // Repeat disabled after the second pulse, then re-enabled.
        ev_q.delete();
        apply_stimulus(MASK | 4'b0100, 4'b0100, 1'b1, 14);
        apply_stimulus(MASK | 4'b0100, 4'b0000, 1'b1, 10);
        u = cyc + 1;
        apply_stimulus(MASK | 4'b0100, 4'b0100, 1'b1, 8);
        apply_stimulus(MASK, 4'b0000, 1'b1, 10);
        a = nth_ev(2, 1'b1, 0);
        check_int("dis_second", nth_ev(2, 1'b1, 1) - a, 8);
        check_int("dis_quiet", count_ev(2, 1'b1, a + 9, u - 1), 0);
        check_int("dis_resume", nth_ev(2, 1'b1, 2) - u, 0);
        check_int("dis_rate1", nth_ev(2, 1'b1, 3) - u, 3);
        check_int("dis_rate2", nth_ev(2, 1'b1, 4) - u, 6);

        // Release accepted on the same edge a repeat is due.
        ev_q.delete();
        apply_stimulus(MASK | 4'b0100, 4'b0100, 1'b1, 14);
        apply_stimulus(MASK, 4'b0100, 1'b1, 12);
        a = nth_ev(2, 1'b1, 0);
        check_int("coll_release_edge", nth_ev(2, 1'b0, 0) - a, 14);
        check_int("coll_last_repeat", nth_ev(2, 1'b1, 2) - a, 11);
        check_int("coll_no_press", count_ev(2, 1'b1, a + 12, cyc), 0);
        apply_stimulus(MASK, 4'b0000, 1'b1, 4);

        // Enable low across a press: level tracks, pulse dropped for good.
        ev_q.delete();
        apply_stimulus(MASK | 4'b0001, 4'b0000, 1'b0, 6);
        check_output("gate_level", btn_level, 4'b0001);
        check_output("gate_press", btn_press, 4'b0000);
        apply_stimulus(MASK | 4'b0001, 4'b0000, 1'b0, 3);
        apply_stimulus(MASK | 4'b0001, 4'b0000, 1'b1, 3);
        check_int("gate_no_replay", count_ev(0, 1'b1, 0, cyc), 0);
        apply_stimulus(MASK, 4'b0000, 1'b1, 8);
        check_int("gate_release", count_ev(0, 1'b0, 0, cyc), 1);

        // Active-low channel 3.
        apply_stimulus(4'b0000, 4'b0000, 1'b1, 6);
        check_output("polarity_press", btn_press, 4'b1000);
        check_output("polarity_level", btn_level, 4'b1000);
        apply_stimulus(MASK, 4'b0000, 1'b1, 8);

        // Simultaneous presses and releases.
        apply_stimulus(MASK | 4'b0011, 4'b0000, 1'b1, 6);
        check_output("multi_press", btn_press, 4'b0011);
        check_output("multi_any", {3'b0, btn_any_press}, 4'b0001);
        apply_stimulus(MASK | 4'b0011, 4'b0000, 1'b1, 1);
        apply_stimulus(MASK, 4'b0000, 1'b1, 6);
        check_output("multi_release", btn_release, 4'b0011);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
